// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit line data memory between fetch (port 0) and load/store (port 1).
// Reads hold the address across the memory's refresh period; writes issue a single-cycle word strobe.
module dmem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned MEM_BYTES   = 1024
) (
    input  logic         CLk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [31:0]  addr0,
    input  logic [31:0]  addr1,
    input  logic [31:0]  wdata0,
    input  logic [31:0]  wdata1,
    output logic         ack0,
    output logic         ack1,
    output logic         err0,
    output logic         err1,
    output logic [127:0] rdata0,
    output logic [127:0] rdata1,
    output logic [31:0]  mem_address,
    output logic [31:0]  mem_inputData,
    output logic         mem_writeMem,
    input  logic [127:0] mem_data,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_PULSE,
        ACK,
        TURN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             port_q;

    logic             gnt_valid;
    logic             gnt_port;
    logic             gnt_we;
    logic [31:0]      gnt_addr;
    logic [31:0]      gnt_wdata;
    logic [32:0]      gnt_last_byte;
    logic             gnt_illegal;

    // Winner selection and range check; 33-bit sum so a high address cannot wrap into range.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_port  = 1'b0;
        if (req0 && req1) begin
            gnt_port = ~last_grant;
        end else if (req1) begin
            gnt_port = 1'b1;
        end
        gnt_we        = gnt_port ? we1 : we0;
        gnt_addr      = gnt_port ? addr1 : addr0;
        gnt_wdata     = gnt_port ? wdata1 : wdata0;
        gnt_last_byte = {1'b0, gnt_addr} + (gnt_we ? 33'd3 : 33'd15);
        gnt_illegal   = gnt_last_byte > 33'(MEM_BYTES - 1);
    end

    always_ff @(posedge CLk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            port_q        <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            mem_address   <= '0;
            mem_inputData <= '0;
            mem_writeMem  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            mem_writeMem <= 1'b0;

            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        last_grant    <= gnt_port;
                        port_q        <= gnt_port;
                        mem_address   <= gnt_addr;
                        mem_inputData <= gnt_wdata;
                        busy          <= 1'b1;
                        if (gnt_illegal) begin
                            state <= ACK;
                            ack0  <= ~gnt_port;
                            ack1  <= gnt_port;
                            err0  <= ~gnt_port;
                            err1  <= gnt_port;
                        end else if (gnt_we) begin
                            state        <= WR_PULSE;
                            mem_writeMem <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= '0;
                        end
                    end
                end

                // Address has been stable across a full refresh period by the time cnt reaches the latency.
                RD_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MEM_LATENCY)) begin
                        state <= ACK;
                        ack0  <= ~port_q;
                        ack1  <= port_q;
                        if (port_q) begin
                            rdata1 <= mem_data;
                        end else begin
                            rdata0 <= mem_data;
                        end
                    end
                end

                WR_PULSE: begin
                    state <= ACK;
                    ack0  <= ~port_q;
                    ack1  <= port_q;
                end

                ACK: begin
                    state <= TURN;
                end

                // Dead cycle lets a registered requester drop req before the next arbitration.
                TURN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Two-requester controller that shares the single 128-bit line data memory between the instruction-fetch unit (port 0) and the load/store unit (port 1). It arbitrates round-robin and sequences each access. It holds the memory address stable long enough for the memory's free-running 4-phase line refresh to reflect it, and issues single-cycle word writes. Each requester gets a one-cycle ack with the captured line or an error.

Parameters:
MEM_LATENCY, 4, refresh period of the data memory in clocks; a read holds the address MEM_LATENCY+1 cycles.
MEM_BYTES, 1024, memory size in bytes; used for range checking.

Ports:
CLk  input  1  system clock; all state updates on posedge (the memory acts on negedge).
reset  input  1  asynchronous, active-high reset.
req0 / req1  input  1  access request; held with we/addr/wdata stable until ack.
we0 / we1  input  1  1 = 32-bit word write, 0 = 128-bit line read.
addr0 / addr1  input  32  byte address.
wdata0 / wdata1  input  32  write data, little-endian bytes.
ack0 / ack1  output  1  one-cycle completion pulse.
err0 / err1  output  1  valid with ack; 1 = address out of range, no access performed.
rdata0 / rdata1  output  128  captured line; updated only on a successful read ack to that port; otherwise held.
mem_address  output  32  to memory address.
mem_inputData  output  32  to memory write data.
mem_writeMem  output  1  to memory write enable.
mem_data  input  128  line from memory.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; cnt 0; last_grant=1 so port 0 wins first.
- States: IDLE, RD_WAIT, WR_PULSE, ACK, TURN.
- IDLE arbitration:
  - Single request: grant it.
  - Both requesting: grant the port not equal to last_grant. Set last_grant to the winner.
  - On grant, register mem_address=addrN, mem_inputData=wdataN and the latched we.
- Range check at grant:
  - Read illegal if addr+15 > MEM_BYTES-1.
  - Write illegal if addr+3 > MEM_BYTES-1.
  - Use 33-bit arithmetic so there is no wrap.
  - Illegal access goes straight to ACK with errN=1. mem_writeMem stays 0 and rdataN is unchanged.
- Read:
  - IDLE -> RD_WAIT with cnt=0. cnt increments each posedge.
  - On the posedge where cnt==MEM_LATENCY, capture mem_data into rdataN and go to ACK.
  - mem_address is stable from grant edge E0 through E5 (5 clocks, 5 negedges).
  - Latency: ack high from E5 to E6.
- Write:
  - IDLE -> WR_PULSE. mem_writeMem=1 for exactly one clock (E0-E1), covering exactly one negedge.
  - Then ACK; ack high E1-E2.
  - A write does not update rdata.
- ACK: ackN=1 (and errN as decided) for one cycle, then TURN.
- TURN: one dead cycle with no grant, so a registered requester can drop req. Then IDLE.
- Held outputs:
  - mem_address / mem_inputData keep their last values outside transactions.
  - mem_writeMem is 0 in every state except WR_PULSE.
- req deasserted mid-transaction is ignored; the transaction completes and acks.
- Reset asserted mid-transaction:
  - Immediate abort; all outputs 0, including mem_writeMem (no partial write pulse beyond reset).
  - State goes to IDLE; rdata cleared to 0.
- Only one transaction is ever in flight. ack0 and ack1 are never both high.

Test Plan:
- Memory preloaded with byte i = i[7:0]. Port 0 reads addr 0x10 -> ack0 exactly 5 cycles after grant; rdata0 = 0x1F1E1D1C1B1A19181716151413121110; err0=0.
- Port 1 writes 0xDEADBEEF to 0x20, then reads 0x20 -> mem_writeMem high for exactly 1 cycle; read returns rdata1[31:0]=0xDEADBEEF and rdata1[39:32]=0x24.
- req0 and req1 both raised the cycle after reset and held, reads to 0x0 and 0x40 -> port 0 acks first, then port 1 (after TURN). Then port 0 again when it re-requests with port 1 also requesting; ack0/ack1 never overlap.
- Port 0 reads 0x3F8 (illegal) and port 1 writes 0x3FC (legal) -> ack0 with err0=1, mem_writeMem never pulses for port 0, rdata0 unchanged. Port 1 acks with err1=0.
- Reset pulsed during RD_WAIT at cnt=2 -> outputs 0 asynchronously, busy=0, no ack. A subsequent read of 0x10 completes normally with the first scenario's values.
